inta_sequencer: RTL and testbench
=================================

Name: inta_sequencer

Overview:
- Responder side of the 8259A interrupt-acknowledge protocol. Drives `int_o` toward the CPU and answers the two-pulse INTA sequence.
- Sets In-Service bits on acknowledge and clears them on EOI commands or in auto-EOI.
- Sits between IRR/IMR storage and the data-bus buffer. Owns the in-service state and drives the interrupt vector onto the bus.

Parameters:
- INTA_SYNC, 1, number of synchronizer flops on `inta_n` (0 = input already synchronous, 1..2 allowed).
- SPURIOUS_ID, 7, IR number reported when a request vanishes before the first INTA.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ir_req  in  8  latched request levels from IRR
- imr  in  8  interrupt mask (1 = masked)
- vec_base  in  5  ICW2 T7..T3
- aeoi  in  1  auto-EOI mode (ICW4)
- inta_n  in  1  CPU interrupt acknowledge, active-low
- eoi_cmd  in  1  one-cycle pulse, OCW2 EOI command
- eoi_specific  in  1  qualifies eoi_cmd: 1 = specific, 0 = non-specific
- eoi_level  in  3  IR number for specific EOI
- int_o  out  1  interrupt request to CPU
- isr  out  8  In-Service Register
- irr_clr  out  8  one-cycle one-hot pulse to clear the acknowledged IRR bit
- vector  out  8  {vec_base, id[2:0]}
- vector_oe  out  1  data-bus drive enable for vector

Behaviour:
- Reset (async, rst_n=0): `isr`=0, `int_o`=0, `irr_clr`=0, `vector`=0, `vector_oe`=0, state=IDLE. Any in-flight sequence is abandoned.
- INTA edges: sampled through INTA_SYNC flops plus one history flop.
  - `fall` = prev & ~cur.
  - `rise` = ~prev & cur.
- Eligibility: `cand` = `ir_req` & ~`imr`. The winner is the lowest set index of `cand`. It is eligible only if its index is below the lowest set index of `isr`; when `isr`=0, any winner is eligible. Fixed priority: IR0 highest, fully nested.
- FSM states: IDLE, PEND, ACK1, GAP, ACK2.
  - IDLE: eligible winner exists -> PEND. `int_o` rises in the same clock as entry to PEND.
  - PEND: eligible winner drops before INTA -> IDLE, `int_o`=0. On `fall` -> ACK1, in the same edge:
    - Latch id = winner, or SPURIOUS_ID if none eligible.
    - If not spurious: set `isr`[id] and pulse `irr_clr`[id] for one cycle.
    - `int_o`=0.
  - ACK1: `rise` -> GAP.
  - GAP: `fall` -> ACK2, `vector_oe`=1, `vector`={vec_base,id}.
  - ACK2: `vector_oe` stays 1 while INTA is low. On `rise` -> IDLE, `vector_oe`=0. If `aeoi`=1 and not spurious, clear `isr`[id] on that edge.
- INTA edges in IDLE are ignored: no vector, no ISR change.
- `vector` holds its last value when `vector_oe`=0.
- EOI (`eoi_cmd`=1, evaluated on the pre-update `isr`):
  - Non-specific: clear the lowest set bit of `isr`.
  - Specific: clear `isr`[eoi_level].
  - `isr`=0 or target bit already 0: no effect.
- Simultaneous ISR set (ACK1 entry) and EOI in one cycle: both apply. The EOI target is computed from the pre-set `isr`, then the new bit is ORed in.
- Simultaneous aeoi clear and EOI: both clears apply.
- Latency:
  - `int_o` rises 1 cycle after `cand` becomes eligible.
  - `isr` set and `irr_clr` occur 1+INTA_SYNC cycles after the first `inta_n` low.
  - `vector_oe` asserts 1+INTA_SYNC cycles after the second `inta_n` low.
- Only one acknowledge in flight. New requests are evaluated again only after returning to IDLE.

Decomposition:
- Shared package pic_pkg:
  - FSM state enum.
  - NUM_IR=8.
  - Function `lowest_set(8b) -> {valid, idx[2:0]}`, used for both winner and ISR-priority lookup.
- One natural sub-module: `inta_edge_detect` (synchronizer plus `fall`/`rise` pulses).

Test Plan:
- Reset mid-ACK2 (`vector_oe`=1) -> `vector_oe`, `isr`, `int_o` all 0 immediately.
- `ir_req`=8'h24, `imr`=0, `vec_base`=5'h11, two INTA pulses:
  - `int_o`=1.
  - After the first pulse: `isr`=8'h04 and `irr_clr`=8'h04 for one cycle.
  - During the second pulse: `vector`=8'h8A, `vector_oe`=1.
- With `isr`=8'h04, `ir_req`=8'h08 -> `int_o` stays 0. Then `ir_req`=8'h02 -> `int_o`=1. After ACK: `isr`=8'h06.
- `isr`=8'h06:
  - Non-specific EOI -> `isr`=8'h04.
  - Specific EOI with `eoi_level`=5 -> `isr` unchanged.
  - Specific EOI with `eoi_level`=2 -> `isr`=8'h00.
- `ir_req`=8'h01 withdrawn after `int_o`=1 but within the same cycle as the first INTA edge -> spurious path: vector={base,3'd7}, `isr` unchanged, `irr_clr`=0.
- `aeoi`=1, `ir_req`=8'h80, `vec_base`=5'h08, full sequence -> `isr`=8'h80 during ACK1/GAP/ACK2, `vector`=8'h47, `isr`=0 after the second INTA rises.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int unsigned NUM_IR = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK1,
        ST_GAP,
        ST_ACK2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } lowest_t;

    // Lowest set bit of an IR-wide vector; IR0 has the highest priority.
    function automatic lowest_t lowest_set(input logic [NUM_IR-1:0] v);
        lowest_t r;
        r = '0;
        for (int unsigned i = 0; i < NUM_IR; i++) begin
            if (v[i] && !r.valid) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Synchronizes the active-low INTA strobe and produces single-cycle
// pulses for its falling (acknowledge start) and rising (end) edges.
module inta_edge_detect #(
    parameter int unsigned INTA_SYNC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic cur;
    logic prev;

    generate
        if (INTA_SYNC == 0) begin : g_nosync
            assign cur = inta_n;
        end else begin : g_sync
            logic [INTA_SYNC-1:0] sync;

            // Synchronizer chain, idles high like the bus strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync <= '1;
                end else begin
                    sync[0] <= inta_n;
                    for (int unsigned i = 1; i < INTA_SYNC; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign cur = sync[INTA_SYNC-1];
        end
    endgenerate

    // History flop used to detect edges of the synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= cur;
        end
    end

    assign fall = prev & ~cur;
    assign rise = ~prev & cur;

endmodule

// File: rtl/inta_sequencer.sv
// Responder side of the 8259A two-pulse INTA handshake: raises int_o for
// an eligible request, owns the In-Service Register and drives the vector.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned INTA_SYNC   = 1,
    parameter int unsigned SPURIOUS_ID = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ir_req,
    input  logic [7:0]  imr,
    input  logic [4:0]  vec_base,
    input  logic        aeoi,
    input  logic        inta_n,
    input  logic        eoi_cmd,
    input  logic        eoi_specific,
    input  logic [2:0]  eoi_level,
    output logic        int_o,
    output logic [7:0]  isr,
    output logic [7:0]  irr_clr,
    output logic [7:0]  vector,
    output logic        vector_oe
);

    state_t     state;
    state_t     state_next;
    logic       fall;
    logic       rise;
    lowest_t    win;
    lowest_t    top;
    logic       eligible;
    logic       ack_take;
    logic       ack_real;
    logic [2:0] id;
    logic       spur;
    logic [7:0] set_mask;
    logic [7:0] eoi_mask;
    logic [7:0] aeoi_mask;

    inta_edge_detect #(
        .INTA_SYNC(INTA_SYNC)
    ) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    // Priority resolution: winning request must outrank every in-service level.
    always_comb begin
        win      = lowest_set(ir_req & ~imr);
        top      = lowest_set(isr);
        eligible = win.valid && (!top.valid || (win.idx < top.idx));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a first INTA edge in PEND wins over a vanishing request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (eligible) state_next = ST_PEND;
            ST_PEND: begin
                if (fall) begin
                    state_next = ST_ACK1;
                end else if (!eligible) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACK1: if (rise) state_next = ST_GAP;
            ST_GAP:  if (fall) state_next = ST_ACK2;
            ST_ACK2: if (rise) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        int_o     = (state == ST_PEND);
        vector_oe = (state == ST_ACK2);
    end

    // ISR update masks: set on acknowledge, clear on EOI and auto-EOI.
    always_comb begin
        ack_take  = (state == ST_PEND) && fall;
        ack_real  = ack_take && eligible;
        set_mask  = '0;
        eoi_mask  = '0;
        aeoi_mask = '0;
        if (ack_real) begin
            set_mask[win.idx] = 1'b1;
        end
        if (eoi_cmd) begin
            if (eoi_specific) begin
                eoi_mask[eoi_level] = 1'b1;
            end else if (top.valid) begin
                eoi_mask[top.idx] = 1'b1;
            end
        end
        if ((state == ST_ACK2) && rise && aeoi && !spur) begin
            aeoi_mask[id] = 1'b1;
        end
    end

    // Acknowledge datapath: latched id, IRR clear pulse, vector and ISR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id      <= '0;
            spur    <= 1'b0;
            irr_clr <= '0;
            vector  <= '0;
            isr     <= '0;
        end else begin
            if (ack_take) begin
                id   <= eligible ? win.idx : 3'(SPURIOUS_ID);
                spur <= !eligible;
            end
            irr_clr <= set_mask;
            if ((state == ST_GAP) && fall) begin
                vector <= {vec_base, id};
            end
            // Clears use the pre-update ISR; the new bit is ORed in afterwards.
            isr <= (isr & ~eoi_mask & ~aeoi_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with INTA_SYNC=1.
module tb_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] ir_req;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       aeoi;
    logic       inta_n;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_o;
    logic [7:0] isr;
    logic [7:0] irr_clr;
    logic [7:0] vector;
    logic       vector_oe;

    int errors = 0;
    int checks = 0;

    // Values captured during a two-pulse acknowledge.
    logic [7:0] o_ack1_isr, o_ack1_clr, o_clr2, o_vec, o_ack2_isr, o_end_isr, o_end_vec;
    logic       o_ack1_int, o_oe, o_end_oe;

    inta_sequencer #(
        .INTA_SYNC   (1),
        .SPURIOUS_ID (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_req       (ir_req),
        .imr          (imr),
        .vec_base     (vec_base),
        .aeoi         (aeoi),
        .inta_n       (inta_n),
        .eoi_cmd      (eoi_cmd),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .int_o        (int_o),
        .isr          (isr),
        .irr_clr      (irr_clr),
        .vector       (vector),
        .vector_oe    (vector_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Two INTA pulses; the IRR model drops the bit the DUT clears.
    task automatic run_ack(input logic drop_req);
        inta_n = 1'b0;
        tick(1);
        if (drop_req) ir_req = 8'h00;
        tick(1);
        o_ack1_isr = isr;
        o_ack1_clr = irr_clr;
        o_ack1_int = int_o;
        ir_req     = ir_req & ~irr_clr;
        tick(1);
        o_clr2 = irr_clr;
        inta_n = 1'b1;
        tick(2);
        inta_n = 1'b0;
        tick(2);
        o_vec      = vector;
        o_oe       = vector_oe;
        o_ack2_isr = isr;
        inta_n = 1'b1;
        tick(2);
        o_end_oe  = vector_oe;
        o_end_isr = isr;
        o_end_vec = vector;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ir_req = 8'h00; imr = 8'h00; vec_base = 5'h00; aeoi = 1'b0;
        inta_n = 1'b1; eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        tick(2);
        checks++;
        if ({int_o, vector_oe, isr, irr_clr, vector} !== 26'h0) begin
            errors++;
            $display("FAIL reset_state: int_o=%b oe=%b isr=%h clr=%h vec=%h required all 0",
                     int_o, vector_oe, isr, irr_clr, vector);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        ir_req = 8'h24; vec_base = 5'h11;
        tick(1);
        checks++;
        if (int_o !== 1'b1) begin errors++; $display("FAIL basic_int: got %b need 1", int_o); end
        run_ack(1'b0);
        checks++;
        if (o_ack1_isr !== 8'h04) begin errors++; $display("FAIL basic_isr: got %h need 04", o_ack1_isr); end
        checks++;
        if (o_ack1_clr !== 8'h04) begin errors++; $display("FAIL basic_irr_clr: got %h need 04", o_ack1_clr); end
        checks++;
        if (o_ack1_int !== 1'b0) begin errors++; $display("FAIL basic_int_drop: got %b need 0", o_ack1_int); end
        checks++;
        if (o_clr2 !== 8'h00) begin errors++; $display("FAIL basic_clr_pulse: got %h need 00", o_clr2); end
        checks++;
        if (o_vec !== 8'h8A || o_oe !== 1'b1) begin
            errors++; $display("FAIL basic_vector: got %h oe=%b need 8a oe=1", o_vec, o_oe);
        end
        checks++;
        if (o_end_oe !== 1'b0 || o_end_isr !== 8'h04 || o_end_vec !== 8'h8A) begin
            errors++; $display("FAIL basic_end: oe=%b isr=%h vec=%h need 0 04 8a", o_end_oe, o_end_isr, o_end_vec);
        end
    endtask

    task automatic test_nested();
        ir_req = 8'h08;
        tick(2);
        checks++;
        if (int_o !== 1'b0) begin errors++; $display("FAIL nested_blocked: got %b need 0", int_o); end
        ir_req = 8'h0A;
        tick(1);
        checks++;
        if (int_o !== 1'b1) begin errors++; $display("FAIL nested_int: got %b need 1", int_o); end
        run_ack(1'b0);
        checks++;
        if (o_end_isr !== 8'h06 || o_vec !== 8'h89) begin
            errors++; $display("FAIL nested_isr: isr=%h vec=%h need 06 89", o_end_isr, o_vec);
        end
    endtask

    task automatic test_eoi();
        eoi_cmd = 1'b1; eoi_specific = 1'b0;
        tick(1);
        eoi_cmd = 1'b0;
        checks++;
        if (isr !== 8'h04) begin errors++; $display("FAIL eoi_nonspecific: got %h need 04", isr); end
        eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5;
        tick(1);
        eoi_cmd = 1'b0;
        checks++;
        if (isr !== 8'h04) begin errors++; $display("FAIL eoi_specific_miss: got %h need 04", isr); end
        eoi_cmd = 1'b1; eoi_level = 3'd2; ir_req = 8'h00;
        tick(1);
        eoi_cmd = 1'b0; eoi_specific = 1'b0;
        checks++;
        if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific_hit: got %h need 00", isr); end
        tick(1);
        checks++;
        if (int_o !== 1'b0) begin errors++; $display("FAIL eoi_idle: int_o=%b need 0", int_o); end
    endtask

    task automatic test_idle_inta();
        run_ack(1'b0);
        checks++;
        if (o_oe !== 1'b0 || o_ack1_isr !== 8'h00 || o_end_vec !== 8'h89 || o_ack1_clr !== 8'h00) begin
            errors++; $display("FAIL idle_inta: oe=%b isr=%h vec=%h clr=%h need 0 00 89 00",
                               o_oe, o_ack1_isr, o_end_vec, o_ack1_clr);
        end
    endtask

    task automatic test_spurious();
        ir_req = 8'h01;
        tick(1);
        checks++;
        if (int_o !== 1'b1) begin errors++; $display("FAIL spur_int: got %b need 1", int_o); end
        run_ack(1'b1);
        checks++;
        if (o_ack1_isr !== 8'h00 || o_ack1_clr !== 8'h00) begin
            errors++; $display("FAIL spur_isr: isr=%h clr=%h need 00 00", o_ack1_isr, o_ack1_clr);
        end
        checks++;
        if (o_vec !== 8'h8F || o_oe !== 1'b1) begin
            errors++; $display("FAIL spur_vector: got %h oe=%b need 8f oe=1", o_vec, o_oe);
        end
        checks++;
        if (o_end_isr !== 8'h00) begin errors++; $display("FAIL spur_end_isr: got %h need 00", o_end_isr); end
    endtask

    task automatic test_aeoi();
        aeoi = 1'b1; ir_req = 8'h80; vec_base = 5'h08;
        tick(1);
        checks++;
        if (int_o !== 1'b1) begin errors++; $display("FAIL aeoi_int: got %b need 1", int_o); end
        run_ack(1'b0);
        checks++;
        if (o_ack1_isr !== 8'h80 || o_ack2_isr !== 8'h80) begin
            errors++; $display("FAIL aeoi_isr_held: ack1=%h ack2=%h need 80 80", o_ack1_isr, o_ack2_isr);
        end
        checks++;
        if (o_vec !== 8'h47) begin errors++; $display("FAIL aeoi_vector: got %h need 47", o_vec); end
        checks++;
        if (o_end_isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %h need 00", o_end_isr); end
        aeoi = 1'b0;
    endtask

    task automatic test_reset_mid_ack2();
        ir_req = 8'h01;
        tick(1);
        inta_n = 1'b0;
        tick(2);
        ir_req = 8'h00;
        inta_n = 1'b1;
        tick(2);
        inta_n = 1'b0;
        tick(2);
        checks++;
        if (vector_oe !== 1'b1 || isr !== 8'h01) begin
            errors++; $display("FAIL pre_reset_ack2: oe=%b isr=%h need 1 01", vector_oe, isr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (vector_oe !== 1'b0 || isr !== 8'h00 || int_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ack2: oe=%b isr=%h int_o=%b need 0 00 0", vector_oe, isr, int_o);
        end
        inta_n = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (vector_oe !== 1'b0 || int_o !== 1'b0 || vector !== 8'h00) begin
            errors++; $display("FAIL post_reset: oe=%b int_o=%b vec=%h need 0 0 00", vector_oe, int_o, vector);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nested();
        test_eoi();
        test_idle_inta();
        test_spurious();
        test_aeoi();
        test_reset_mid_ack2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
